price_avg: RTL and testbench
============================

# price_avg

Monte Carlo averaging stage directly downstream of the pricing unit. Accepts one discounted per-path payoff per handshake, accumulates exactly 2^LOG2_N samples, then emits the rounded sample mean as the option price estimate on a valid/ready output. Optionally also emits a sample variance for confidence-interval reporting. Sits between the pricing unit and the top-level 16-bit result output.

## Interface

- PRICE_W, 16, width of unsigned per-path price (fixed-point, same format as pricing unit output)
- LOG2_N, 10, log2 of paths per estimate; N = 2^LOG2_N
- clk  in  1  clock; single clock domain, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; clears accumulators and begins a new run
- in_valid  in  1  price sample valid
- in_ready  out  1  block accepts a sample this cycle
- price  in  PRICE_W  per-path price
- out_valid  out  1  result valid; held until accepted
- out_ready  in  1  consumer accepts result
- avg  out  PRICE_W  rounded mean
- var  out  2*PRICE_W  population variance (only with PRICE_AVG_VAR_EN)
- busy  out  1  high in ACCUM or CALC
- count  out  LOG2_N+1  samples accepted in current run

## Operation

- States: IDLE, ACCUM, CALC, HOLD.
- IDLE: in_ready=0, out_valid=0. start -> ACCUM.
- ACCUM: in_ready=1. Transfer when in_valid&&in_ready: acc += price, count += 1 (acc width PRICE_W+LOG2_N; cannot overflow). When transfer makes count==N -> CALC.
- CALC (one cycle): avg_reg = (acc + 2^(LOG2_N-1)) >> LOG2_N (round half up; max result 2^PRICE_W-1, no saturation needed). -> HOLD.
- HOLD: out_valid=1, avg/var stable. out_valid&&out_ready -> IDLE.
- start is honoured in every state and has priority: clears acc, sumsq, count, drops any held result, -> ACCUM. start with a simultaneous sample in ACCUM: sample discarded.
- in_valid outside ACCUM: ignored, no side effects.
- rst: state IDLE, acc=0, sumsq=0, count=0, avg=0, var=0, in_ready=0, out_valid=0, busy=0. Reset mid-run discards the partial run.

## Timing

- start at cycle t -> in_ready=1 and busy=1 at t+1.
- Zero-bubble input: one sample per cycle at full rate.
- Nth transfer at cycle T -> CALC at T+1 -> out_valid=1 at T+2. Latency last sample to result: 2 cycles.
- Accepted at cycle H (out_valid&&out_ready) -> out_valid=0 at H+1; next start at H+1 -> ACCUM at H+2.
- avg/var retain last result after HOLD until next CALC or rst.
- count visible the cycle after each transfer; equals N in CALC and HOLD.

## Configuration

- PRICE_AVG_VAR_EN defined: extra accumulator sumsq (2*PRICE_W+LOG2_N bits) adds price*price per transfer; CALC computes var = (sumsq >> LOG2_N) - ((acc*acc) >> 2*LOG2_N), truncating shifts, clamped to 0 if negative. Timing unchanged.
- Not defined: no multiplier, no sumsq; var port absent.

## Test plan

- Reset/idle: assert rst 2 cycles with in_valid=1 -> all outputs 0, count stays 0.
- Basic mean (LOG2_N=2): start, prices 100,200,300,401 back-to-back -> out_valid 2 cycles after 4th sample, avg=250 (1001+2)>>2.
- Full scale (LOG2_N=2): four samples 65535 -> avg=65535, no wrap; variance build var=0.
- Variance (LOG2_N=2, VAR_EN): 100,200,300,400 -> avg=250, var=12500; constant 7,7,7,7 -> var=0.
- Backpressure/gaps: in_valid toggled randomly, out_ready held 0 for 5 cycles -> avg stable throughout HOLD, single transfer on out_ready, extra in_valid during CALC/HOLD ignored (count stays N).
- Restart: start after 2 of 4 samples with simultaneous in_valid -> count=0, that sample dropped; next 4 samples 10,10,10,10 -> avg=10; rst mid-run -> IDLE, no out_valid.

Source files
------------

// File: rtl/price_avg.sv
// Monte Carlo averaging stage: accumulates 2^LOG2_N path prices, then emits the rounded mean.
// Define PRICE_AVG_VAR_EN to add the population-variance output var_out.
module price_avg #(
    parameter int PRICE_W = 16,
    parameter int LOG2_N  = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PRICE_W-1:0]   price,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PRICE_W-1:0]   avg,
`ifdef PRICE_AVG_VAR_EN
    output logic [2*PRICE_W-1:0] var_out,
`endif
    output logic                 busy,
    output logic [LOG2_N:0]      count
);

    localparam int ACC_W = PRICE_W + LOG2_N;
    localparam int PW2   = 2 * PRICE_W;
    localparam logic [ACC_W-1:0] HALF = ACC_W'(1) << (LOG2_N - 1);
    localparam logic [LOG2_N:0]  LAST = (LOG2_N + 1)'((1 << LOG2_N) - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_CALC, S_HOLD} state_t;

    state_t               state_q, state_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [LOG2_N:0]      count_q, count_d;
    logic [PRICE_W-1:0]   avg_q, avg_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q, busy_d;

`ifdef PRICE_AVG_VAR_EN
    localparam int SQ_W   = PW2 + LOG2_N;
    localparam int ACC2_W = 2 * ACC_W;
    logic [SQ_W-1:0]      sumsq_q, sumsq_d;
    logic [PW2-1:0]       var_q, var_d;
    logic [PW2-1:0]       price_sq, mean_of_sq, sq_of_mean;
    logic [ACC2_W-1:0]    acc_sq;

    always_comb begin
        price_sq   = PW2'(price) * PW2'(price);
        acc_sq     = ACC2_W'(acc_q) * ACC2_W'(acc_q);
        mean_of_sq = PW2'(sumsq_q >> LOG2_N);
        sq_of_mean = PW2'(acc_sq >> (2 * LOG2_N));
    end
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        avg_d   = avg_q;
`ifdef PRICE_AVG_VAR_EN
        sumsq_d = sumsq_q;
        var_d   = var_q;
`endif
        // start wins over everything, including a sample offered in the same cycle
        if (start) begin
            state_d = S_ACCUM;
            acc_d   = '0;
            count_d = '0;
`ifdef PRICE_AVG_VAR_EN
            sumsq_d = '0;
`endif
        end else begin
            case (state_q)
                S_ACCUM: begin
                    if (in_valid && in_ready_q) begin
                        acc_d   = acc_q + ACC_W'(price);
                        count_d = count_q + 1'b1;
`ifdef PRICE_AVG_VAR_EN
                        sumsq_d = sumsq_q + SQ_W'(price_sq);
`endif
                        if (count_q == LAST) state_d = S_CALC;
                    end
                end
                S_CALC: begin
                    avg_d = PRICE_W'((acc_q + HALF) >> LOG2_N);
`ifdef PRICE_AVG_VAR_EN
                    var_d = (mean_of_sq >= sq_of_mean) ? (mean_of_sq - sq_of_mean) : '0;
`endif
                    state_d = S_HOLD;
                end
                S_HOLD: begin
                    if (out_ready) state_d = S_IDLE;
                end
                default: ;
            endcase
        end
        in_ready_d  = (state_d == S_ACCUM);
        out_valid_d = (state_d == S_HOLD);
        busy_d      = (state_d == S_ACCUM) || (state_d == S_CALC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            avg_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef PRICE_AVG_VAR_EN
            sumsq_q     <= '0;
            var_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            avg_q       <= avg_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef PRICE_AVG_VAR_EN
            sumsq_q     <= sumsq_d;
            var_q       <= var_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign count     = count_q;
    assign avg       = avg_q;
`ifdef PRICE_AVG_VAR_EN
    assign var_out   = var_q;
`endif

endmodule

// File: tb/tb_price_avg.sv
// Randomized bench for price_avg (N=4) with a phase-level reference model checked every cycle.
module tb_price_avg;
    localparam int PW = 16;
    localparam int LN = 2;
    localparam int N  = 4;

    logic          clk = 1'b0;
    logic          rst, start, in_valid, out_ready;
    logic [PW-1:0] price;
    logic          in_ready, out_valid, busy;
    logic [PW-1:0] avg;
    logic [LN:0]   count;
`ifdef PRICE_AVG_VAR_EN
    logic [2*PW-1:0] var_out;
`endif

    price_avg #(.PRICE_W(PW), .LOG2_N(LN)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .price(price), .out_valid(out_valid), .out_ready(out_ready), .avg(avg),
`ifdef PRICE_AVG_VAR_EN
        .var_out(var_out),
`endif
        .busy(busy), .count(count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 0 idle, 1 accepting, 2 computing, 3 holding a result
    int     m_phase = 0;
    int     m_cnt   = 0;
    longint m_sum   = 0;
    longint m_sumsq = 0;
    longint m_avg   = 0;
    longint m_var   = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_cnt = 0; m_sum = 0; m_sumsq = 0; m_avg = 0; m_var = 0;
        end else if (start) begin
            m_phase = 1; m_cnt = 0; m_sum = 0; m_sumsq = 0;
        end else if (m_phase == 1) begin
            if (in_valid) begin
                m_sum   += longint'(price);
                m_sumsq += longint'(price) * longint'(price);
                m_cnt++;
                if (m_cnt == N) m_phase = 2;
            end
        end else if (m_phase == 2) begin
            longint ms, sm;
            m_avg = (m_sum + N / 2) / N;
            ms = m_sumsq / N;
            sm = (m_sum * m_sum) / (N * N);
            m_var = (ms >= sm) ? ms - sm : 0;
            m_phase = 3;
        end else if (m_phase == 3) begin
            if (out_ready) m_phase = 0;
        end
    end

    always @(negedge clk) begin
        check("in_ready",  in_ready,  64'(m_phase == 1));
        check("out_valid", out_valid, 64'(m_phase == 3));
        check("busy",      busy,      64'(m_phase == 1 || m_phase == 2));
        check("count",     count,     64'(m_cnt));
        check("avg",       avg,       64'(m_avg));
`ifdef PRICE_AVG_VAR_EN
        check("var",       var_out,   64'(m_var));
`endif
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_run(input int p0, input int p1, input int p2, input int p3,
                          input bit gaps, input int hold_cyc, input bit no_start,
                          input longint exp_avg, input longint exp_var);
        int ps[4];
        int w;
        ps = '{p0, p1, p2, p3};
        out_ready = 1'b0;
        if (!no_start) begin
            start = 1'b1; in_valid = 1'b0; tick(); start = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            while (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0; price = PW'($urandom); tick();
            end
            in_valid = 1'b1; price = PW'(ps[i]); tick();
        end
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 8) begin tick(); w++; end
        check("result_arrives", out_valid, 1);
        if (exp_avg >= 0) check("avg_literal", avg, 64'(exp_avg));
`ifdef PRICE_AVG_VAR_EN
        if (exp_var >= 0) check("var_literal", var_out, 64'(exp_var));
`else
        if (exp_var >= 0) check("avg_vs_model", avg, 64'(m_avg));
`endif
        for (int h = 0; h < hold_cyc; h++) begin
            in_valid = 1'($urandom); price = PW'($urandom); tick();
        end
        in_valid = 1'b0;
        check("count_in_hold", count, N);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        check("released", out_valid, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b1; out_ready = 1'b1; price = 16'h1234;
        tick(); tick();
        check("rst_count", count, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_avg", avg, 0);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        check("idle_count", count, 0);

        do_run(100, 200, 300, 401, 1'b0, 5, 1'b0, 250, -1);
        do_run(65535, 65535, 65535, 65535, 1'b0, 2, 1'b0, 65535, 0);
        do_run(100, 200, 300, 400, 1'b1, 5, 1'b0, 250, 12500);
        do_run(7, 7, 7, 7, 1'b1, 3, 1'b0, 7, 0);

        // restart after two samples with a simultaneous sample that must be dropped
        start = 1'b1; tick(); start = 1'b0;
        in_valid = 1'b1; price = 50; tick(); price = 60; tick();
        start = 1'b1; price = 999; tick(); start = 1'b0; in_valid = 1'b0;
        check("restart_count", count, 0);
        do_run(10, 10, 10, 10, 1'b0, 1, 1'b1, 10, 0);

        // reset in the middle of a run
        start = 1'b1; tick(); start = 1'b0;
        in_valid = 1'b1; price = 500; tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            price = 16'(k + 1); tick();
            check("rst_mid_count", count, 0);
            check("rst_mid_out_valid", out_valid, 0);
        end
        in_valid = 1'b0;

        for (int r = 0; r < 25; r++) begin
            do_run(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                   int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                   1'b1, int'($urandom_range(0, 6)), 1'b0, -1, -1);
            if (r % 5 == 4) begin
                // new start while a result is held drops it
                do_run(1, 2, 3, 4, 1'b0, 0, 1'b0, 3, -1);
                start = 1'b1; tick(); start = 1'b0;
                check("start_in_hold_drops", out_valid, 0);
                do_run(1, 1, 1, 2, 1'b0, 1, 1'b1, 1, -1);
            end
        end

        tick(); tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
